// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller and its baud counter.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } rx_state_e;

    typedef struct packed {
        logic parity_en;
        logic parity_sel;
        logic stop_sel;
    } frame_cfg_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud tick generator: fires at the half-bit point in half_mode, else at the mid-bit point.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic half_mode,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = ~clear & (cnt_q == (half_mode ? HalfLast : FullLast));

    // The counter restarts on every tick so consecutive samples are one bit apart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive controller: sequences bit sampling for an external datapath and owns the
// output holding register with its valid/ready handshake and error flags.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       valid_in,
    input  logic [7:0] data_out,
    input  logic       parity_ok,
    input  logic       parity_en,
    input  logic       parity_sel,
    input  logic       stop_sel,
    output logic       rx_sel,
    output logic       rx_sr_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    rx_state_e  state_q, state_d;
    frame_cfg_t cfg_q, cfg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       par_pend_q, par_pend_d;
    logic       par_err_acc_q, par_err_acc_d;
    logic       frm_err_acc_q, frm_err_acc_d;

    logic       rx_sel_q;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic tick, cnt_clear, half_mode, sr_en;

    // Parity sense is applied by the datapath; it is still held per frame with the rest.
    logic unused_parity_sel;
    assign unused_parity_sel = cfg_q.parity_sel;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .half_mode(half_mode),
        .tick     (tick)
    );

    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        bit_cnt_d     = bit_cnt_q;
        stop_cnt_d    = stop_cnt_q;
        par_pend_d    = 1'b0;
        par_err_acc_d = par_err_acc_q;
        frm_err_acc_d = frm_err_acc_q;
        cnt_clear     = 1'b0;
        half_mode     = 1'b0;
        sr_en         = 1'b0;

        // Parity compare is read one cycle after its shift so the datapath has settled.
        if (par_pend_q) begin
            par_err_acc_d = ~parity_ok;
        end

        unique case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                if (valid_in) begin
                    state_d       = StStart;
                    cfg_d         = '{parity_en: parity_en, parity_sel: parity_sel,
                                      stop_sel: stop_sel};
                    bit_cnt_d     = 3'd0;
                    stop_cnt_d    = 1'b0;
                    par_err_acc_d = 1'b0;
                    frm_err_acc_d = 1'b0;
                end
            end
            StStart: begin
                half_mode = 1'b1;
                if (tick) begin
                    if (rx_in) begin
                        state_d = StIdle;
                    end else begin
                        sr_en   = 1'b1;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    sr_en     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = cfg_q.parity_en ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    sr_en      = 1'b1;
                    par_pend_d = 1'b1;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    sr_en = 1'b1;
                    if (!rx_in) begin
                        frm_err_acc_d = 1'b1;
                    end
                    if (stop_cnt_q == cfg_q.stop_sel) begin
                        state_d = StDone;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A load in DONE wins over a same-cycle accept, so an accept then reload keeps rx_valid.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        if (state_q == StDone) begin
            rx_data_d    = data_out;
            rx_valid_d   = 1'b1;
            parity_err_d = par_err_acc_q;
            frame_err_d  = frm_err_acc_q;
            overrun_d    = rx_valid_q & ~rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cfg_q         <= '0;
            bit_cnt_q     <= 3'd0;
            stop_cnt_q    <= 1'b0;
            par_pend_q    <= 1'b0;
            par_err_acc_q <= 1'b0;
            frm_err_acc_q <= 1'b0;
            rx_sel_q      <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            par_pend_q    <= par_pend_d;
            par_err_acc_q <= par_err_acc_d;
            frm_err_acc_q <= frm_err_acc_d;
            rx_sel_q      <= (state_d != StDone);
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_sel     = rx_sel_q;
    assign rx_sr_en   = sr_en;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller with a behavioural datapath (edge detect, shift, parity).
module tb_uart_rx_controller;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset, rx_in, rx_ready, parity_en, parity_sel, stop_sel;
    logic       valid_in, parity_ok;
    logic [7:0] data_out;
    logic       rx_sel, rx_sr_en, rx_valid, parity_err, frame_err, overrun;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_err    = 0;

    uart_rx_controller #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .parity_ok (parity_ok),
        .parity_en (parity_en),
        .parity_sel(parity_sel),
        .stop_sel  (stop_sel),
        .rx_sel    (rx_sel),
        .rx_sr_en  (rx_sr_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Datapath model: line mux, falling-edge detector, bit capture indexed by shift count.
    logic       line, prev_q, dp_pbit_q;
    logic [3:0] idx_q;
    logic [7:0] dp_data_q;

    assign line      = rx_sel ? rx_in : 1'b1;
    assign valid_in  = prev_q & ~line;
    assign data_out  = dp_data_q;
    assign parity_ok = (((^dp_data_q) ^ dp_pbit_q) == parity_sel);

    always @(posedge clk) begin
        prev_q <= reset ? 1'b1 : line;
        if (reset || !rx_sel) begin
            idx_q <= 4'd0;
        end else if (rx_sr_en) begin
            if (idx_q >= 4'd1 && idx_q <= 4'd8) dp_data_q[3'(idx_q - 4'd1)] <= rx_in;
            else if (idx_q == 4'd9) dp_pbit_q <= rx_in;
            idx_q <= idx_q + 4'd1;
        end
    end

    // Event counters and latency capture.
    int cyc = 0, sr_total = 0, sel_low_total = 0, t0 = 0, t1 = 0;
    bit meas_en = 1'b0, m_started = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_sr_en) sr_total <= sr_total + 1;
        if (!reset && !rx_sel) sel_low_total <= sel_low_total + 1;
        if (meas_en && !m_started && valid_in) begin
            m_started <= 1'b1;
            t0        <= cyc;
        end
        if (m_started && !m_done && rx_valid) begin
            m_done <= 1'b1;
            t1     <= cyc;
        end
    end

    bit ack_done = 1'b0;
    int sr_base, sel_base, lat;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        rx_in = b;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (ack_done) rx_ready = ~rx_sel;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop2);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        if (parity_en) hold_bit(pbit);
        hold_bit(1'b1);
        if (stop_sel) hold_bit(stop2);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check(tag, 16'(rx_valid), 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        rx_in      = 1'b1;
        rx_ready   = 1'b0;
        parity_en  = 1'b0;
        parity_sel = 1'b0;
        stop_sel   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_sel", 16'(rx_sel), 16'h0);
        check("rst_sr_en", 16'(rx_sr_en), 16'h0);
        check("rst_valid", 16'(rx_valid), 16'h0);
        check("rst_data", 16'(rx_data), 16'h00);
        check("rst_perr", 16'(parity_err), 16'h0);
        check("rst_ferr", 16'(frame_err), 16'h0);
        check("rst_ovr", 16'(overrun), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rx_sel", 16'(rx_sel), 16'h1);
        repeat (4) @(negedge clk);

        // 8'hA5, no parity, one stop bit; latency expected 8 + 16*9 + 1 = 153.
        sr_base  = sr_total;
        sel_base = sel_low_total;
        meas_en  = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1);
        meas_en = 1'b0;
        check("a5_sr_en_count", 16'(sr_total - sr_base), 16'd10);
        check("a5_done_rx_sel_low", 16'(sel_low_total - sel_base), 16'd1);
        check("a5_valid", 16'(rx_valid), 16'h1);
        check("a5_data", 16'(rx_data), 16'hA5);
        check("a5_perr", 16'(parity_err), 16'h0);
        check("a5_ferr", 16'(frame_err), 16'h0);
        check("a5_ovr", 16'(overrun), 16'h0);
        // t1 is captured one edge after rx_valid rises.
        lat = t1 - t0 - 1;
        check("a5_latency_in_152_154", 16'(lat >= 152 && lat <= 154), 16'h1);
        accept("a5_accept");

        // 8'h3C even parity: correct bit is 0, send 1.
        parity_en = 1'b1;
        sr_base   = sr_total;
        send_frame(8'h3C, 1'b1, 1'b1);
        check("par_bad_sr_en_count", 16'(sr_total - sr_base), 16'd11);
        check("par_bad_data", 16'(rx_data), 16'h3C);
        check("par_bad_perr", 16'(parity_err), 16'h1);
        check("par_bad_ferr", 16'(frame_err), 16'h0);
        accept("par_bad_accept");
        send_frame(8'h3C, 1'b0, 1'b1);
        check("par_good_data", 16'(rx_data), 16'h3C);
        check("par_good_perr", 16'(parity_err), 16'h0);
        accept("par_good_accept");

        // 8'hFF, two stop bits, second driven low.
        parity_en = 1'b0;
        stop_sel  = 1'b1;
        sr_base   = sr_total;
        send_frame(8'hFF, 1'b0, 1'b0);
        check("ferr_sr_en_count", 16'(sr_total - sr_base), 16'd11);
        check("ferr_data", 16'(rx_data), 16'hFF);
        check("ferr_flag", 16'(frame_err), 16'h1);
        check("ferr_perr", 16'(parity_err), 16'h0);
        accept("ferr_accept");
        stop_sel = 1'b0;
        repeat (8) @(negedge clk);

        // 3-cycle low glitch on an idle line.
        sr_base = sr_total;
        rx_in   = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_sr_en_count", 16'(sr_total - sr_base), 16'd0);
        check("glitch_valid", 16'(rx_valid), 16'h0);

        // Two frames without accept: second overwrites and flags overrun.
        send_frame(8'h11, 1'b0, 1'b1);
        check("ovr_first_data", 16'(rx_data), 16'h11);
        check("ovr_first_flag", 16'(overrun), 16'h0);
        send_frame(8'h22, 1'b0, 1'b1);
        check("ovr_second_data", 16'(rx_data), 16'h22);
        check("ovr_second_flag", 16'(overrun), 16'h1);
        check("ovr_second_valid", 16'(rx_valid), 16'h1);
        accept("ovr_accept");

        // Accept landing on the DONE cycle: accept-then-load, no overrun.
        send_frame(8'h44, 1'b0, 1'b1);
        check("atl_first_valid", 16'(rx_valid), 16'h1);
        ack_done = 1'b1;
        send_frame(8'h33, 1'b0, 1'b1);
        ack_done = 1'b0;
        rx_ready = 1'b0;
        check("atl_valid", 16'(rx_valid), 16'h1);
        check("atl_data", 16'(rx_data), 16'h33);
        check("atl_ovr", 16'(overrun), 16'h0);
        accept("atl_accept");

        // Reset during DATA bit 4 of 8'h55.
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(i[0] ? 1'b0 : 1'b1);
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_rx_sel", 16'(rx_sel), 16'h0);
        check("mid_rst_sr_en", 16'(rx_sr_en), 16'h0);
        check("mid_rst_valid", 16'(rx_valid), 16'h0);
        check("mid_rst_data", 16'(rx_data), 16'h00);
        check("mid_rst_flags", 16'({parity_err, frame_err, overrun}), 16'h0);
        rx_in = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_after_rx_sel", 16'(rx_sel), 16'h1);
        sr_base = sr_total;
        repeat (200) @(negedge clk);
        check("mid_rst_no_valid", 16'(rx_valid), 16'h0);
        check("mid_rst_no_sr_en", 16'(sr_total - sr_base), 16'd0);

        sr_base = sr_total;
        send_frame(8'h0F, 1'b0, 1'b1);
        check("next_sr_en_count", 16'(sr_total - sr_base), 16'd10);
        check("next_valid", 16'(rx_valid), 16'h1);
        check("next_data", 16'(rx_data), 16'h0F);
        check("next_flags", 16'({parity_err, frame_err, overrun}), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clocks per UART bit; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx_in, input, 1 bit: raw serial line, already synchronised, idle high.
REQ-005 SHALL have port valid_in, input, 1 bit: start-edge pulse from the datapath falling-edge detector.
REQ-006 SHALL have port data_out, input, 8 bits: datapath shift-register data field.
REQ-007 SHALL have port parity_ok, input, 1 bit: datapath parity compare result.
REQ-008 SHALL have ports parity_en, parity_sel and stop_sel, input, 1 bit each: static frame config (parity present; 0 = even / 1 = odd; 0 = one stop bit / 1 = two stop bits).
REQ-009 SHALL have port rx_sel, output, 1 bit: datapath line mux select (1 = pass rx_in, 0 = force idle).
REQ-010 SHALL have port rx_sr_en, output, 1 bit: one-cycle shift-enable pulse per sampled bit.
REQ-011 SHALL have ports rx_data (output, 8 bits), rx_valid (output, 1 bit) and rx_ready (input, 1 bit): output holding register with valid/ready handshake.
REQ-012 SHALL have ports parity_err, frame_err and overrun, output, 1 bit each: error flags qualified by rx_valid.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-014 In IDLE, valid_in=1 SHALL clear the baud counter and move to START.
REQ-015 In START, the line SHALL be sampled at count CLKS_PER_BIT/2-1: rx_in=1 means glitch, return to IDLE with no rx_sr_en; rx_in=0 pulses rx_sr_en, restarts the counter and moves to DATA.
REQ-016 In DATA, PARITY and STOP, each bit SHALL be sampled once at count CLKS_PER_BIT-1 (mid-bit), with one rx_sr_en pulse per sample and the counter restarted.
REQ-017 DATA SHALL take exactly 8 samples, tracked by a 3-bit counter that wraps 7->0 on exit; it then goes to PARITY if parity_en=1, else to STOP.
REQ-018 PARITY SHALL take 1 sample and latch parity_err = ~parity_ok one cycle after rx_sr_en, giving the datapath shift time.
REQ-019 STOP SHALL take 1 + stop_sel samples; frame_err is set if any sampled stop bit has rx_in=0.
REQ-020 DONE SHALL last exactly 1 cycle: load rx_data <= data_out, set rx_valid=1 and return to IDLE; rx_sel=0 during DONE.
REQ-021 rx_sel SHALL be 1 in every state except DONE and the reset cycle.
REQ-022 Handshake: rx_valid SHALL hold with rx_data and flags stable until a cycle with rx_valid & rx_ready, and then clear on the next edge.
REQ-023 If DONE coincides with rx_valid=1 and rx_ready=0, SHALL overwrite rx_data and flags and set overrun=1.
REQ-024 If DONE coincides with rx_valid & rx_ready, SHALL treat it as accept-then-load: rx_valid stays 1 and overrun=0.
REQ-025 The parity_sel and stop_sel config inputs SHALL only be sampled in IDLE on the valid_in cycle and held for the whole frame.
REQ-026 The total frame latency from the valid_in cycle to rx_valid rising SHALL be CLKS_PER_BIT/2 + CLKS_PER_BIT*(8+parity_en+1+stop_sel) + 1 cycles, within +/-1.

Reset
REQ-027 On reset=1 at posedge, SHALL go to IDLE and set: counters 0, rx_sel=0, rx_sr_en=0, rx_valid=0, rx_data=8'h00, parity_err=0, frame_err=0, overrun=0.
REQ-028 Reset mid-frame SHALL abort the frame with no rx_valid; the first cycle after reset returns to IDLE with rx_sel=1.

Structure
REQ-029 The state enum and the default CLKS_PER_BIT constant SHALL live in shared package uart_pkg.
REQ-030 The mid-bit/half-bit tick generator SHALL be a sub-module uart_baud_cnt with inputs clear and half_mode and a tick output.

Verification
REQ-031 The bench SHALL run CLKS_PER_BIT=16 with no parity and one stop bit, sending 8'hA5 LSB-first: expect rx_sr_en pulses = 10, rx_valid=1, rx_data=8'hA5, all flags 0.
REQ-032 The bench SHALL use parity_en=1 with even parity and a corrupted parity bit on 8'h3C: expect rx_data=8'h3C and parity_err=1.
REQ-033 The bench SHALL use stop_sel=1 with the second stop bit driven 0 on 8'hFF: expect frame_err=1.
REQ-034 The bench SHALL apply a 3-cycle low glitch on an idle line: expect a return to IDLE with zero rx_sr_en and no rx_valid.
REQ-035 The bench SHALL send two frames 8'h11 then 8'h22 with rx_ready=0: expect rx_data=8'h22 and overrun=1; rx_ready=1 for 1 cycle then clears rx_valid.
REQ-036 The bench SHALL assert reset during DATA bit 4 of 8'h55: expect all outputs at reset values, no rx_valid, and the next frame 8'h0F received correctly.
